// File: rtl/sseg_scan_mux.sv
// Four-digit common-anode scanner: frame-aligned value capture, optional leading-zero blanking.
// Latency: an/digit follow the registered slot with no pipeline; free-running, no backpressure.
module sseg_scan_mux #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        lz_blank,
  output logic [3:0]  digit,
  output logic [3:0]  an,
  output logic        frame_done
);

  localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0] pcnt;
  logic [1:0]    slot;
  logic [15:0]   pend;
  logic [15:0]   disp;
  logic          disp_lz;

  logic          slot_end;
  logic          boundary;
  logic [3:0]    nib;
  logic          lead_zero;

  assign slot_end = (pcnt == PMAX);
  assign boundary = slot_end && (slot == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt       <= '0;
      slot       <= 2'd0;
      pend       <= 16'h0000;
      disp       <= 16'h0000;
      disp_lz    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      pcnt       <= slot_end ? '0 : pcnt + 1'b1;
      frame_done <= boundary;
      if (slot_end) begin
        slot <= slot + 2'd1;
      end
      if (load) begin
        pend <= value;
      end
      // A load on the boundary cycle bypasses pend so it is shown this frame.
      if (boundary) begin
        disp    <= load ? value : pend;
        disp_lz <= lz_blank;
      end
    end
  end

  always_comb begin
    nib       = 4'h0;
    lead_zero = 1'b0;
    case (slot)
      2'd0: nib = disp[3:0];
      2'd1: begin
        nib       = disp[7:4];
        lead_zero = (disp[15:4] == 12'h000);
      end
      2'd2: begin
        nib       = disp[11:8];
        lead_zero = (disp[15:8] == 8'h00);
      end
      default: begin
        nib       = disp[15:12];
        lead_zero = (disp[15:12] == 4'h0);
      end
    endcase
    if (disp_lz && lead_zero) begin
      digit = 4'h0;
      an    = 4'b1111;
    end else begin
      digit = nib;
      an    = ~(4'b0001 << slot);
    end
  end

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed bench for sseg_scan_mux at REFRESH_DIV=4 and REFRESH_DIV=1.
module tb_sseg_scan_mux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [3:0]  digit;
  logic [3:0]  an;
  logic        frame_done;

  logic        rst1_n = 1'b0;
  logic [15:0] value1 = 16'h0000;
  logic        load1 = 1'b0;
  logic [3:0]  digit1;
  logic [3:0]  an1;
  logic        frame_done1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  sseg_scan_mux #(.REFRESH_DIV(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load), .lz_blank(lz_blank),
    .digit(digit), .an(an), .frame_done(frame_done)
  );

  sseg_scan_mux #(.REFRESH_DIV(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n), .value(value1), .load(load1), .lz_blank(1'b0),
    .digit(digit1), .an(an1), .frame_done(frame_done1)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after rising edge number e (counted from reset release), sampling on the falling edge.
  task automatic goto(input int e);
    while (cyc < e) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  // Present a load strobe that is captured on edge e.
  task automatic load_at(input int e, input logic [15:0] v);
    goto(e - 1);
    value = v;
    load  = 1'b1;
    goto(e);
    load  = 1'b0;
  endtask

  initial begin
    int cnt;

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_an", {12'h0, an}, 16'h000E);
    check("rst_digit", {12'h0, digit}, 16'h0000);
    check("rst_fd", {15'h0, frame_done}, 16'h0000);
    rst_n = 1'b1;
    cyc = 0;

    // 1: scan order, frame 0 shows zeros
    load_at(2, 16'h1234);
    goto(5);
    check("f0_s1_an", {12'h0, an}, 16'h000D);
    check("f0_s1_digit", {12'h0, digit}, 16'h0000);
    goto(9);
    check("f0_s2_an", {12'h0, an}, 16'h000B);
    goto(13);
    check("f0_s3_an", {12'h0, an}, 16'h0007);
    goto(15);
    check("f0_no_fd", {15'h0, frame_done}, 16'h0000);
    goto(16);
    check("f1_fd", {15'h0, frame_done}, 16'h0001);
    check("f1_s0", {8'h0, an, digit}, 16'h00E4);
    goto(17);
    check("f1_fd_one_cycle", {15'h0, frame_done}, 16'h0000);
    goto(19);
    check("f1_s0_hold", {8'h0, an, digit}, 16'h00E4);
    goto(20);
    check("f1_s1", {8'h0, an, digit}, 16'h00D3);

    // 2: mid-frame load does not tear
    load_at(22, 16'hABCD);
    goto(23);
    check("f1_s1_hold", {8'h0, an, digit}, 16'h00D3);
    goto(24);
    check("f1_s2", {8'h0, an, digit}, 16'h00B2);
    goto(28);
    check("f1_s3", {8'h0, an, digit}, 16'h0071);
    goto(32);
    check("f2_s0", {8'h0, an, digit}, 16'h00ED);
    goto(36);
    check("f2_s1", {8'h0, an, digit}, 16'h00DC);
    goto(40);
    check("f2_s2", {8'h0, an, digit}, 16'h00BB);
    goto(44);
    check("f2_s3", {8'h0, an, digit}, 16'h007A);
    load_at(48, 16'h5555);
    check("bnd_load_s0", {8'h0, an, digit}, 16'h00E5);
    check("bnd_load_fd", {15'h0, frame_done}, 16'h0001);
    goto(52);
    check("bnd_load_s1", {8'h0, an, digit}, 16'h00D5);

    // 3: leading-zero blanking
    lz_blank = 1'b1;
    load_at(50 + 4, 16'h0042);
    goto(64);
    check("lz42_s0", {8'h0, an, digit}, 16'h00E2);
    goto(68);
    check("lz42_s1", {8'h0, an, digit}, 16'h00D4);
    goto(72);
    check("lz42_s2", {8'h0, an, digit}, 16'h00F0);
    goto(76);
    check("lz42_s3", {8'h0, an, digit}, 16'h00F0);
    load_at(78, 16'h0000);
    goto(80);
    check("lz0_s0", {8'h0, an, digit}, 16'h00E0);
    goto(84);
    check("lz0_s1", {8'h0, an, digit}, 16'h00F0);
    load_at(90, 16'h1000);
    goto(96);
    check("lz1000_s0", {8'h0, an, digit}, 16'h00E0);
    goto(100);
    check("lz1000_s1", {8'h0, an, digit}, 16'h00D0);
    goto(108);
    check("lz1000_s3", {8'h0, an, digit}, 16'h0071);

    // 4: blanking enable is frame-aligned
    lz_blank = 1'b0;
    load_at(110, 16'h0007);
    goto(116);
    check("tog_s1_lit", {8'h0, an, digit}, 16'h00D0);
    goto(121);
    lz_blank = 1'b1;
    goto(124);
    check("tog_s3_lit", {8'h0, an, digit}, 16'h0070);
    goto(128);
    check("tog_next_s0", {8'h0, an, digit}, 16'h00E7);
    goto(132);
    check("tog_next_s1", {8'h0, an, digit}, 16'h00F0);

    // 5: synchronous reset in slot 3 with FFFF displayed
    lz_blank = 1'b0;
    load_at(134, 16'hFFFF);
    goto(156);
    check("ffff_s3", {8'h0, an, digit}, 16'h007F);
    goto(157);
    rst_n = 1'b0;
    goto(158);
    rst_n = 1'b1;
    check("mid_rst_out", {8'h0, an, digit}, 16'h00E0);
    check("mid_rst_fd", {15'h0, frame_done}, 16'h0000);
    goto(161);
    check("mid_rst_pcnt0", {12'h0, an}, 16'h000E);
    goto(162);
    check("mid_rst_s1", {12'h0, an}, 16'h000D);
    cnt = 0;
    for (int i = 163; i <= 173; i++) begin
      goto(i);
      cnt += int'(frame_done);
    end
    check("mid_rst_no_fd", 16'(cnt), 16'd0);
    goto(174);
    check("mid_rst_fd_bnd", {15'h0, frame_done}, 16'h0001);
    check("mid_rst_disp0", {8'h0, an, digit}, 16'h00E0);
    goto(186);
    check("mid_rst_s3_zero", {8'h0, an, digit}, 16'h0070);

    // 6: REFRESH_DIV=1
    rst1_n = 1'b1;
    cyc = 0;
    goto(1);
    value1 = 16'h9876;
    load1  = 1'b1;
    goto(2);
    load1  = 1'b0;
    check("d1_s2_old", {8'h0, an1, digit1}, 16'h00B0);
    goto(3);
    check("d1_s3", {8'h0, an1, digit1}, 16'h0070);
    goto(4);
    check("d1_bnd", {7'h0, frame_done1, an1, digit1}, 16'h01E6);
    goto(5);
    value1 = 16'h1111;
    load1  = 1'b1;
    check("d1_s1", {8'h0, an1, digit1}, 16'h00D7);
    goto(6);
    load1  = 1'b0;
    check("d1_s2", {8'h0, an1, digit1}, 16'h00B8);
    goto(7);
    check("d1_s3_new", {8'h0, an1, digit1}, 16'h0079);
    goto(8);
    check("d1_bnd2", {7'h0, frame_done1, an1, digit1}, 16'h01E1);
    cnt = 0;
    for (int i = 9; i <= 24; i++) begin
      goto(i);
      cnt += int'(frame_done1);
    end
    check("d1_fd_rate", 16'(cnt), 16'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
